demux_32bit_reg: RTL and testbench
==================================

# demux_32bit_reg

Registered 1-to-2 demultiplexer for 32-bit words: the routing counterpart of the 32-bit 2:1 operand selector.
- Accepts one word per cycle on a valid/ready input and steers it, by a per-word select bit, into one of two single-entry output registers.
- Each output register has its own valid/ready handshake and a delivered-word counter.
- Sits between the ALU result path and two downstream consumers (e.g. a register-file write port and a debug/trace sink), so a stalled consumer never blocks traffic routed to the other one.

## Interface
- WIDTH, 32, data word width
- CNT_W, 8, width of each delivered-word counter
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle (combinational)
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 0 → port 0, 1 → port 1; qualified by in_valid
- out0_valid  output  1  port 0 register holds a word
- out0_ready  input  1  port 0 consumer takes the word this cycle
- out0_data  output  WIDTH  port 0 word
- out1_valid / out1_ready / out1_data  same as port 0, for port 1
- cnt0  output  CNT_W  words delivered on port 0 (modulo 2^CNT_W)
- cnt1  output  CNT_W  words delivered on port 1 (modulo 2^CNT_W)

## Operation
- Per-port state: EMPTY (outN_valid=0) or FULL (outN_valid=1).
- Input handshake:
  - in_ready = in_sel ? (!out1_valid | out1_ready) : (!out0_valid | out0_ready).
  - Accept = in_valid & in_ready.
  - in_ready depends only on in_sel and the selected port; it never depends on in_valid.
- Port N transitions each cycle:
  - EMPTY, accept to N → FULL; outN_data ← in_data.
  - FULL, outN_ready=1, accept to N → FULL; outN_data ← in_data (back-to-back, no bubble).
  - FULL, outN_ready=1, no accept to N → EMPTY; outN_data keeps its last value.
  - FULL, outN_ready=0 → FULL; outN_data held stable. in_ready=0 while in_sel=N.
  - EMPTY, no accept → EMPTY.
- Ports are independent: a FULL-stalled port 0 does not affect acceptance to port 1, and vice versa.
- Counters:
  - cntN increments by 1 on each cycle with outN_valid & outN_ready.
  - Wraps from 2^CNT_W-1 to 0, with no sticky flag.
- Words are never dropped or duplicated except by reset. Order is preserved per port.
- in_data and in_sel are ignored when in_valid=0.

## Timing
- Reset (clock edge with reset=1):
  - out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0.
  - Reset takes priority over any simultaneous accept or drain.
  - While reset=1, in_ready still follows its equation, but no accept takes effect.
- Reset mid-operation: any held words are discarded, and counters restart from 0 on the cycle after reset deasserts.
- Latency: a word accepted at edge k appears with outN_valid=1 from edge k onward, i.e. visible in cycle k+1. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained to either port while its consumer holds ready=1. Alternating in_sel also gives 1 word/cycle aggregate.
- Simultaneous events:
  - Drain plus load on the same port in one cycle: the new word replaces the old one, valid stays 1, and cntN increments.
  - Drain on one port plus load on the other: both take effect in the same cycle.
- Outputs outN_valid, outN_data and cntN are registered. in_ready is the only combinational output.

## Test plan
- Reset/idle: assert reset for 2 cycles with in_valid=1 → both valids 0, both data 0, cnt0=cnt1=0. After release, in_ready=1 for both in_sel values.
- Basic route: send 0xDEADBEEF with in_sel=0, then 0x12345678 with in_sel=1, both consumers ready=1:
  - out0_data=0xDEADBEEF valid 1 cycle after accept.
  - out1_data=0x12345678 valid 1 cycle after its accept.
  - Final cnt0=1, cnt1=1.
- Backpressure isolation: out0_ready=0, send 0xA to port 0, then 0xB to port 0, then 0xC to port 1:
  - 0xA held on out0.
  - in_ready=0 while presenting 0xB.
  - 0xC accepted and delivered on out1.
  - After out0_ready=1: 0xA delivered, then 0xB. cnt0=2, cnt1=1.
- Full throughput: 16 consecutive words 0..15 to port 1 with out1_ready=1 → in_ready stays 1 throughout; out1_data sequence is 0..15 on consecutive cycles with no bubble; cnt1=16.
- Counter wrap: deliver 257 words on port 0 with CNT_W=8 → cnt0 reads 255 after word 255, 0 after word 256, 1 after word 257.
- Reset mid-operation: hold 0x55 on out0 and 0x66 on out1, both ready=0, then pulse reset for 1 cycle → both valids 0, data 0, counters 0; no stale word appears after reset deasserts.

Source files
------------

// File: rtl/demux_32bit_reg_if.sv
// demux_32bit_reg_if: input handshake, two output handshakes and delivery counters of the demux
interface demux_32bit_reg_if #(parameter int WIDTH = 32, parameter int CNT_W = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
endinterface

// File: rtl/demux_32bit_reg.sv
// demux_32bit_reg: registered 1-to-2 word demultiplexer with per-port handshake and delivery counters
module demux_32bit_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic              clock,
    input logic              reset,
    demux_32bit_reg_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state [2];
    state_t           state_nxt [2];
    logic [WIDTH-1:0] data [2];
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       rdy;
    logic [1:0]       ld;
    logic [1:0]       dr;
    logic             acc;
    always_comb begin
        rdy[0]       = (state[0] == EMPTY) || bus.out0_ready;
        rdy[1]       = (state[1] == EMPTY) || bus.out1_ready;
        dr[0]        = (state[0] == FULL) && bus.out0_ready;
        dr[1]        = (state[1] == FULL) && bus.out1_ready;
        bus.in_ready = bus.in_sel ? rdy[1] : rdy[0];
        acc          = bus.in_valid && bus.in_ready;
        ld[0]        = acc && !bus.in_sel;
        ld[1]        = acc && bus.in_sel;
        // a load wins over a drain so back-to-back words leave no bubble
        for (int i = 0; i < 2; i++)
            state_nxt[i] = ld[i] ? FULL : dr[i] ? EMPTY : state[i];
    end
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                state[i] <= EMPTY;
                data[i]  <= '0;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_nxt[i];
                if (ld[i]) data[i] <= bus.in_data;
                cnt[i]   <= cnt[i] + CNT_W'(dr[i]);
            end
        end
    end
    assign bus.out0_valid = (state[0] == FULL);
    assign bus.out1_valid = (state[1] == FULL);
    assign bus.out0_data  = data[0];
    assign bus.out1_data  = data[1];
    assign bus.cnt0       = cnt[0];
    assign bus.cnt1       = cnt[1];
endmodule

// File: tb/tb_demux_32bit_reg.sv
// tb_demux_32bit_reg: directed self-checking bench for demux_32bit_reg
module tb_demux_32bit_reg;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    demux_32bit_reg_if #(.WIDTH(32), .CNT_W(8)) bus ();
    demux_32bit_reg #(.WIDTH(32), .CNT_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sel, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
    endtask

    task automatic pulse_reset;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b1;
        bus.in_sel     = 1'b0;
        bus.in_data    = 32'hFFFF_FFFF;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        // reset for two cycles with a word presented
        tick();
        tick();
        chk("rst_v0", bus.out0_valid, 0);
        chk("rst_v1", bus.out1_valid, 0);
        chk("rst_d0", bus.out0_data, 0);
        chk("rst_d1", bus.out1_data, 0);
        chk("rst_c0", bus.cnt0, 0);
        chk("rst_c1", bus.cnt1, 0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 1'b0;
        #1 chk("idle_rdy0", bus.in_ready, 1);
        bus.in_sel = 1'b1;
        #1 chk("idle_rdy1", bus.in_ready, 1);

        // basic route
        send(1'b0, 32'hDEAD_BEEF);
        #1 chk("basic_rdy", bus.in_ready, 1);
        tick();
        chk("basic_v0", bus.out0_valid, 1);
        chk("basic_d0", bus.out0_data, 32'hDEAD_BEEF);
        send(1'b1, 32'h1234_5678);
        tick();
        chk("basic_v1", bus.out1_valid, 1);
        chk("basic_d1", bus.out1_data, 32'h1234_5678);
        chk("basic_v0_drained", bus.out0_valid, 0);
        bus.in_valid = 1'b0;
        tick();
        chk("basic_c0", bus.cnt0, 1);
        chk("basic_c1", bus.cnt1, 1);
        chk("basic_v1_drained", bus.out1_valid, 0);
        chk("basic_d0_kept", bus.out0_data, 32'hDEAD_BEEF);

        // backpressure isolation
        pulse_reset();
        bus.out0_ready = 1'b0;
        send(1'b0, 32'hA);
        tick();
        chk("bp_v0", bus.out0_valid, 1);
        chk("bp_d0_a", bus.out0_data, 32'hA);
        send(1'b0, 32'hB);
        #1 chk("bp_rdy_b", bus.in_ready, 0);
        tick();
        chk("bp_d0_held", bus.out0_data, 32'hA);
        send(1'b1, 32'hC);
        #1 chk("bp_rdy_c", bus.in_ready, 1);
        tick();
        chk("bp_v1", bus.out1_valid, 1);
        chk("bp_d1", bus.out1_data, 32'hC);
        chk("bp_d0_still", bus.out0_data, 32'hA);
        chk("bp_c0_zero", bus.cnt0, 0);
        bus.out0_ready = 1'b1;
        send(1'b0, 32'hB);
        #1 chk("bp_rdy_b2", bus.in_ready, 1);
        tick();
        chk("bp_d0_b", bus.out0_data, 32'hB);
        chk("bp_c0_one", bus.cnt0, 1);
        chk("bp_c1_one", bus.cnt1, 1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_c0", bus.cnt0, 2);
        chk("bp_c1", bus.cnt1, 1);
        chk("bp_v0_end", bus.out0_valid, 0);

        // full throughput to port 1
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 32'(i));
            #1 chk("tp_rdy", bus.in_ready, 1);
            tick();
            chk("tp_v1", bus.out1_valid, 1);
            chk("tp_d1", bus.out1_data, 32'(i));
            chk("tp_c1", bus.cnt1, 32'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("tp_c1_final", bus.cnt1, 16);
        chk("tp_v1_end", bus.out1_valid, 0);

        // counter wrap on port 0
        pulse_reset();
        for (int i = 1; i <= 257; i++) begin
            send(1'b0, 32'(i));
            tick();
            if (i == 256) chk("wrap_255", bus.cnt0, 255);
            if (i == 257) chk("wrap_0", bus.cnt0, 0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("wrap_1", bus.cnt0, 1);

        // reset mid-operation discards held words
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        send(1'b0, 32'h55);
        tick();
        send(1'b1, 32'h66);
        tick();
        chk("mid_v0_pre", bus.out0_valid, 1);
        chk("mid_d1_pre", bus.out1_data, 32'h66);
        send(1'b1, 32'h77);
        reset = 1'b1;
        #1 chk("mid_rdy_in_reset", bus.in_ready, 0);
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_v0", bus.out0_valid, 0);
        chk("mid_v1", bus.out1_valid, 0);
        chk("mid_d0", bus.out0_data, 0);
        chk("mid_d1", bus.out1_data, 0);
        chk("mid_c0", bus.cnt0, 0);
        chk("mid_c1", bus.cnt1, 0);
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        tick();
        tick();
        chk("mid_v0_after", bus.out0_valid, 0);
        chk("mid_v1_after", bus.out1_valid, 0);
        chk("mid_c0_after", bus.cnt0, 0);
        chk("mid_c1_after", bus.cnt1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
